sha256_msg_padder: RTL and testbench

Single-block SHA-256 message padder that sits directly in front of the `sha_256` core. It collects a byte stream, builds the padded 512-bit message block (message bytes, 0x80 marker, zero fill, 64-bit big-endian bit length), and holds it for the core under a valid/ready handshake. Messages longer than MAX_BYTES are truncated and flagged.

---
 rtl/sha256_msg_padder.sv | 131 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// Single-block SHA-256 message padder.
// Collects a byte stream and builds one padded 512-bit block: the message
// bytes, then the 0x80 marker, then zero fill, then the 64-bit big-endian
// bit length. The block is held under a valid/ready handshake until the
// hash core takes it. A message that reaches MAX_BYTES without byte_last
// is cut off at that point and flagged with trunc_err.
module sha256_msg_padder #(
    parameter int MAX_BYTES = 55
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [5:0]   msg_len,
    output logic         trunc_err
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] PAD     = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [5:0]  cnt_reg;
    logic        byte_ready_reg;
    logic        block_valid_reg;
    logic [5:0]  msg_len_reg;
    logic        trunc_err_reg;
    logic [63:0] len_field_reg;

    logic [5:0]  cnt_inc;
    logic        accept;
    logic        hit_max;
    logic        release_hs;

    // byte_ready_reg is only ever high in COLLECT, so it alone qualifies a byte.
    assign accept     = byte_valid && byte_ready_reg;
    assign cnt_inc    = cnt_reg + 6'd1;
    assign hit_max    = (cnt_inc == MAX_CNT);
    assign release_hs = (state_reg == HOLD) && block_valid_reg && block_ready;

    // Next-state decode for the COLLECT -> PAD -> HOLD cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && (byte_last || hit_max)) state_next = PAD;
            PAD:     state_next = HOLD;
            HOLD:    if (release_hs) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Control registers: state, byte counter, handshake flags and length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= COLLECT;
            byte_ready_reg  <= 1'b0;
            cnt_reg         <= 6'd0;
            block_valid_reg <= 1'b0;
            msg_len_reg     <= 6'd0;
            trunc_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered from the next state so byte_ready never depends
            // combinationally on byte_valid or block_ready.
            byte_ready_reg <= (state_next == COLLECT);
            if (release_hs) begin
                cnt_reg         <= 6'd0;
                block_valid_reg <= 1'b0;
                trunc_err_reg   <= 1'b0;
            end else if (state_reg == PAD) begin
                msg_len_reg     <= cnt_reg;
                block_valid_reg <= 1'b1;
            end else if (accept) begin
                cnt_reg <= cnt_inc;
                if (hit_max && !byte_last) trunc_err_reg <= 1'b1;
            end
        end
    end

    // Trailing 64-bit length field, written once in PAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_field_reg <= 64'd0;
        end else if (release_hs) begin
            len_field_reg <= 64'd0;
        end else if (state_reg == PAD) begin
            len_field_reg <= {55'd0, cnt_reg, 3'b000};
        end
    end

    // One register per message byte lane; lane 0 is the first byte (MSB end).
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : gen_lane
            localparam logic [5:0] LANE = 6'(gi);
            logic [7:0] lane_reg;

            // Lane takes its message byte in COLLECT, then marker/zero in PAD.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (release_hs) begin
                    lane_reg <= 8'h00;
                end else if (state_reg == PAD) begin
                    if (cnt_reg == LANE)
                        lane_reg <= 8'h80;
                    else if (LANE > cnt_reg)
                        lane_reg <= 8'h00;
                end else if (accept && (cnt_reg == LANE)) begin
                    lane_reg <= byte_in;
                end
            end

            assign block_out[511-8*gi -: 8] = lane_reg;
        end
    endgenerate

    assign block_out[63:0] = len_field_reg;
    assign byte_ready      = byte_ready_reg;
    assign block_valid     = block_valid_reg;
    assign msg_len         = msg_len_reg;
    assign trunc_err       = trunc_err_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: short messages, back-to-back with a
// held block, full 55-byte message, truncation, async reset, stalling source.
module tb_sha256_msg_padder;

    logic         clk;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic [5:0]   msg_len;
    logic         trunc_err;

    int total = 0;
    int bad   = 0;

    sha256_msg_padder #(.MAX_BYTES(55)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .msg_len     (msg_len),
        .trunc_err   (trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%0h", tag, obs);
    endtask

    // Step one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and keep it up until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_ready", {511'd0, byte_ready}, 512'd1);
        step();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        chk("wait_ready", {511'd0, byte_ready}, 512'd1);
    endtask

    // Last byte was just accepted: expect PAD now, block_valid one edge later.
    task automatic check_block(input string tag, input logic [511:0] exp_blk,
                               input logic [5:0] exp_len, input logic exp_trunc);
        chk({tag, "_pad_cycle_valid"}, {511'd0, block_valid}, 512'd0);
        step();
        chk({tag, "_valid"}, {511'd0, block_valid}, 512'd1);
        chk({tag, "_block"}, block_out, exp_blk);
        chk({tag, "_len"}, {506'd0, msg_len}, {506'd0, exp_len});
        chk({tag, "_trunc"}, {511'd0, trunc_err}, {511'd0, exp_trunc});
    endtask

    logic [511:0] exp_abc;
    logic [511:0] exp_aaa;
    logic [511:0] exp_z55;
    logic [511:0] exp_a5;
    logic [511:0] held;
    int accepted;
    int late_ready;

    initial begin
        exp_abc = {32'h61626380, 416'd0, 64'h18};
        exp_aaa = {32'h61616180, 416'd0, 64'h18};
        exp_z55 = {440'd0, 8'h80, 64'h1B8};
        exp_a5  = {{55{8'hA5}}, 8'h80, 64'h1B8};

        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; block_ready = 1'b1;
        step(); step();
        chk("rst_block_valid", {511'd0, block_valid}, 512'd0);
        chk("rst_byte_ready",  {511'd0, byte_ready},  512'd0);
        chk("rst_block_out",   block_out, 512'd0);
        chk("rst_msg_len",     {506'd0, msg_len}, 512'd0);
        chk("rst_trunc",       {511'd0, trunc_err}, 512'd0);
        #2 rst = 1'b0;
        wait_ready();

        // "abc" with block_ready high: one HOLD cycle then release.
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        check_block("abc", exp_abc, 6'd3, 1'b0);
        step();
        chk("abc_release_valid", {511'd0, block_valid}, 512'd0);
        chk("abc_release_ready", {511'd0, byte_ready}, 512'd1);
        chk("abc_release_clear", block_out, 512'd0);

        // "abc" held for 5 cycles, then "aaa" back-to-back.
        block_ready = 1'b0;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        check_block("abc_held", exp_abc, 6'd3, 1'b0);
        held = block_out;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_stable_block", block_out, held);
            chk("hold_byte_ready", {511'd0, byte_ready}, 512'd0);
            chk("hold_valid", {511'd0, block_valid}, 512'd1);
        end
        block_ready = 1'b1;
        step();
        chk("held_release_valid", {511'd0, block_valid}, 512'd0);
        chk("held_release_ready", {511'd0, byte_ready}, 512'd1);
        send_byte(8'h61, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h61, 1'b1);
        check_block("aaa", exp_aaa, 6'd3, 1'b0);
        step();

        // 55 zero bytes, last on the 55th.
        wait_ready();
        for (int i = 0; i < 55; i++) send_byte(8'h00, (i == 54));
        check_block("z55", exp_z55, 6'd55, 1'b0);
        step();

        // 60 bytes offered without last: truncation at 55.
        wait_ready();
        block_ready = 1'b0;
        accepted = 0;
        late_ready = 0;
        byte_in = 8'hA5;
        byte_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (byte_ready) begin
                accepted++;
                if (i >= 55) late_ready++;
            end
            step();
        end
        byte_valid = 1'b0;
        chk("trunc_accepted", 512'(accepted), 512'd55);
        chk("trunc_no_ready_after_55", 512'(late_ready), 512'd0);
        chk("trunc_valid", {511'd0, block_valid}, 512'd1);
        chk("trunc_block", block_out, exp_a5);
        chk("trunc_len", {506'd0, msg_len}, 512'd55);
        chk("trunc_flag", {511'd0, trunc_err}, 512'd1);
        block_ready = 1'b1;
        step();
        chk("trunc_flag_cleared", {511'd0, trunc_err}, 512'd0);
        chk("trunc_release_valid", {511'd0, block_valid}, 512'd0);

        // Async reset mid-collect, checked between clock edges.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_collect_ready", {511'd0, byte_ready}, 512'd0);
        chk("arst_collect_block", block_out, 512'd0);
        step();
        #2 rst = 1'b0;
        wait_ready();

        // Async reset while in HOLD.
        block_ready = 1'b0;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        step();
        chk("arst_hold_pre_valid", {511'd0, block_valid}, 512'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_hold_valid", {511'd0, block_valid}, 512'd0);
        chk("arst_hold_block", block_out, 512'd0);
        chk("arst_hold_len", {506'd0, msg_len}, 512'd0);
        chk("arst_hold_ready", {511'd0, byte_ready}, 512'd0);
        step();
        #2 rst = 1'b0;
        block_ready = 1'b1;
        wait_ready();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        check_block("abc_after_rst", exp_abc, 6'd3, 1'b0);
        step();

        // Stalling source: idle cycle between every byte.
        wait_ready();
        send_byte(8'h61, 1'b0);
        step();
        send_byte(8'h62, 1'b0);
        step();
        send_byte(8'h63, 1'b1);
        check_block("abc_stall", exp_abc, 6'd3, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
